// File: rtl/alu_seq_ctrl_pkg.sv
// rtl/alu_seq_ctrl_pkg.sv - shared opcode, state and op-class definitions
package alu_seq_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } seq_state_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_LDR = 4'h2,
    OP_AND = 4'h3,
    OP_XOR = 4'h4,
    OP_MLD = 4'h5,
    OP_LDI = 4'h6,
    OP_SHL = 4'h7,
    OP_SHR = 4'h8,
    OP_NOT = 4'h9,
    OP_STR = 4'hA,
    OP_MST = 4'hB,
    OP_CLR = 4'hC,
    OP_JMP = 4'hD,
    OP_BRN = 4'hE,
    OP_BRZ = 4'hF
  } op_mne_t;

  // Ops whose ALU result is written back to the accumulator and flags.
  function automatic logic is_wb(op_mne_t op);
    case (op)
      OP_ADD, OP_SUB, OP_LDR, OP_AND, OP_XOR,
      OP_MLD, OP_LDI, OP_SHL, OP_SHR, OP_NOT: is_wb = 1'b1;
      default:                                is_wb = 1'b0;
    endcase
  endfunction

  function automatic logic is_shift(op_mne_t op);
    is_shift = (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// rtl/alu_seq_ctrl_alu.sv - combinational 8-bit alu
module alu_seq_ctrl_alu
  import alu_seq_ctrl_pkg::*;
#(
  parameter int SHAMT_W = 3
) (
  input  op_mne_t           op,
  input  logic [DATA_W-1:0] in_acc,
  input  logic [DATA_W-1:0] in_a,
  output logic [DATA_W-1:0] out_acc,
  output logic              carry,
  output logic              zero,
  output logic              neg
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide    = '0;
    out_acc = in_acc;
    carry   = 1'b0;
    case (op)
      OP_ADD: begin
        wide    = {1'b0, in_acc} + {1'b0, in_a};
        out_acc = wide[DATA_W-1:0];
        carry   = wide[DATA_W];
      end
      OP_SUB: begin
        wide    = {1'b0, in_acc} - {1'b0, in_a};
        out_acc = wide[DATA_W-1:0];
        carry   = wide[DATA_W];
      end
      OP_LDR, OP_MLD, OP_LDI: out_acc = in_a;
      OP_AND:                 out_acc = in_acc & in_a;
      OP_XOR:                 out_acc = in_acc ^ in_a;
      OP_NOT:                 out_acc = ~in_acc;
      OP_SHL:                 out_acc = in_acc << in_a[SHAMT_W-1:0];
      OP_SHR:                 out_acc = in_acc >> in_a[SHAMT_W-1:0];
      OP_CLR:                 out_acc = '0;
      default:                out_acc = in_acc;
    endcase
    zero = (out_acc == '0);
    neg  = out_acc[DATA_W-1];
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - accumulator/flag sequencer around one alu
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int SHAMT_W    = 3,
  parameter bit STEP_SHIFT = 1'b1
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_opnd,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_taken,
  output logic              z_flag,
  output logic              n_flag
);

  seq_state_t        state, state_nxt;
  op_mne_t           cur_op, alu_op, in_op;
  logic [SHAMT_W-1:0] cnt, cnt_nxt, shamt;
  logic [DATA_W-1:0] acc, alu_in_a, alu_acc;
  logic              z_q, n_q, taken_q, taken_nxt;
  logic              accept, exec;
  logic              alu_carry, alu_zero, alu_neg, alu_unused;

  assign in_op = op_mne_t'(cmd_op);
  assign shamt = cmd_opnd[SHAMT_W-1:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    alu_op    = in_op;
    alu_in_a  = cmd_opnd;
    exec      = 1'b0;
    taken_nxt = 1'b0;
    cmd_ready = reset_n && ((state == IDLE) || ((state == RESP) && res_ready));
    accept    = cmd_valid && cmd_ready;
    case (in_op)
      OP_JMP:  taken_nxt = 1'b1;
      OP_BRN:  taken_nxt = n_q;
      OP_BRZ:  taken_nxt = z_q;
      default: taken_nxt = 1'b0;
    endcase
    case (state)
      IDLE, RESP: begin
        if (state == RESP && res_ready) state_nxt = IDLE;
        if (accept) begin
          exec      = 1'b1;
          state_nxt = RESP;
          // The accept cycle performs the first shift step itself.
          if (is_shift(in_op) && STEP_SHIFT) begin
            alu_in_a = (shamt == '0) ? 8'd0 : 8'd1;
            if (shamt > SHAMT_W'(1)) begin
              state_nxt = SHIFT;
              cnt_nxt   = shamt - SHAMT_W'(1);
            end
          end
        end
      end
      SHIFT: begin
        exec     = 1'b1;
        alu_op   = cur_op;
        alu_in_a = 8'd1;
        cnt_nxt  = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_op  <= OP_ADD;
      acc     <= '0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cur_op  <= in_op;
        taken_q <= taken_nxt;
      end
      if (exec) begin
        if (is_wb(alu_op)) begin
          acc <= alu_acc;
          z_q <= (alu_acc == '0);
          n_q <= alu_acc[DATA_W-1];
        end else if (alu_op == OP_CLR) begin
          acc <= '0;
          z_q <= 1'b0;
          n_q <= 1'b0;
        end
      end
    end
  end

  alu_seq_ctrl_alu #(.SHAMT_W(SHAMT_W)) u_alu (
    .op      (alu_op),
    .in_acc  (acc),
    .in_a    (alu_in_a),
    .out_acc (alu_acc),
    .carry   (alu_carry),
    .zero    (alu_zero),
    .neg     (alu_neg)
  );

  assign alu_unused = ^{alu_carry, alu_zero, alu_neg};

  assign res_valid = (state == RESP);
  assign res_data  = acc;
  assign res_taken = taken_q;
  assign z_flag    = z_q;
  assign n_flag    = n_q;

endmodule
